imem_loader: RTL and testbench

Boot-time writer for the core's 128-word instruction memory. It consumes a byte stream from the UART receiver, checks a framed image (magic, length, little-endian words, checksum), and writes each 32-bit word to the instruction RAM write port. It holds the core in reset for the duration of a load and releases it only after a clean load.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_byte_packer.sv | 44 ++++
 rtl/imem_loader.sv | 216 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory boot loader.
// FSM state codes, failure codes and the default frame start byte.
package imem_loader_pkg;

    // Loader FSM state codes
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HDR    = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_LEN_HI = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_CSUM   = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_ERR    = 3'd7;

    // Failure reason reported on err_code
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler for the boot loader.
// The last byte of a word is forwarded combinationally, so word/word_valid
// are valid in the same cycle as the lane-3 byte strobe.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  idx_q;
    logic [23:0] lane_q;

    // Lane 3 comes straight from the input to avoid an extra cycle
    always_comb begin
        word       = {byte_data, lane_q};
        word_valid = byte_valid && (idx_q == 2'(BYTES_PER_WORD - 1));
    end

    // Store lanes 0..2 and advance the lane index on every byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= 2'd0;
            lane_q <= 24'd0;
        end else if (clear) begin
            idx_q  <= 2'd0;
            lane_q <= 24'd0;
        end else if (byte_valid) begin
            case (idx_q)
                2'd0:    lane_q[7:0]   <= byte_data;
                2'd1:    lane_q[15:8]  <= byte_data;
                2'd2:    lane_q[23:16] <= byte_data;
                default: lane_q        <= lane_q;
            endcase
            idx_q <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Parses MAGIC, LEN_LO, LEN_HI, 4*N little-endian data bytes, CSUM from the
// UART byte stream, writes each word to the instruction RAM and holds the
// core in reset until a clean load completes.
// Optional: define IMEM_LOADER_TIMEOUT_EN to abort a stalled load after
// TIMEOUT_CYCLES idle cycles (err_code 3).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned DEPTH_WORDS    = 128,
    parameter logic [7:0]  MAGIC          = DEFAULT_MAGIC,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_req,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_d, error_d;
    logic [1:0]        err_code_d;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [31:0]       wr_data_d;
    logic              hold_d, busy_d;
    logic [15:0]       len_rx;

    logic              pk_clear, pk_valid, pk_word_valid;
    logic [31:0]       pk_word;

    // Only bytes accepted in DATA reach the packer; a colliding boot_req drops the byte
    always_comb begin
        pk_valid = rx_valid && !boot_req && (state_q == ST_DATA);
        pk_clear = boot_req || (rx_valid && (state_q == ST_LEN_HI));
        len_rx   = {rx_data, len_lo_q};
    end

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_data  (rx_data),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

`ifdef IMEM_LOADER_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic        tmo_timed, tmo_fire;

    // Idle-cycle counter, only running while a frame is partly received
    always_comb begin
        tmo_timed = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                    (state_q == ST_DATA)   || (state_q == ST_CSUM);
        tmo_fire  = tmo_timed && !rx_valid && !boot_req && (tmo_q == TIMEOUT_CYCLES - 1);
        if (boot_req || rx_valid || !tmo_timed) begin
            tmo_d = 32'd0;
        end else begin
            tmo_d = tmo_q + 32'd1;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= 32'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Frame parser: next state, counters, sticky status and write port
    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        sum_d      = sum_q;
        addr_d     = addr_q;
        done_d     = done;
        error_d    = error;
        err_code_d = err_code;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;

        if (boot_req) begin
            state_d    = ST_HDR;
            len_lo_d   = 8'd0;
            len_d      = 16'd0;
            word_cnt_d = 16'd0;
            sum_d      = 8'd0;
            addr_d     = '0;
            done_d     = 1'b0;
            error_d    = 1'b0;
            err_code_d = ERR_NONE;
        end else if (rx_valid) begin
            case (state_q)
                ST_HDR: begin
                    if (rx_data == MAGIC) begin
                        state_d = ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    len_lo_d = rx_data;
                    state_d  = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    if ((len_rx == 16'd0) || (32'(len_rx) > DEPTH_WORDS)) begin
                        state_d    = ST_ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_BAD_LEN;
                    end else begin
                        state_d    = ST_DATA;
                        len_d      = len_rx;
                        word_cnt_d = 16'd0;
                        sum_d      = 8'd0;
                        addr_d     = '0;
                    end
                end
                ST_DATA: begin
                    sum_d = sum_q + rx_data;
                    if (pk_word_valid) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = pk_word;
                        addr_d     = addr_q + ADDR_W'(4);
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (word_cnt_q + 16'd1 == len_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (rx_data == sum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                end
                default: ;
            endcase
        end
`ifdef IMEM_LOADER_TIMEOUT_EN
        else if (tmo_fire) begin
            state_d    = ST_ERR;
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
`endif

        // Status outputs are registered from the next state
        hold_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        busy_d = hold_d && (state_d != ST_ERR);
    end

    // State, counters and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_lo_q   <= 8'd0;
            len_q      <= 16'd0;
            word_cnt_q <= 16'd0;
            sum_q      <= 8'd0;
            addr_q     <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 32'd0;
            core_hold  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            sum_q      <= sum_d;
            addr_q     <= addr_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            core_hold  <= hold_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
            err_code   <= err_code_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes are queued as frames
// are driven and popped as wr_en pulses appear.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 12;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk;
    logic              reset;
    logic              boot_req;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;

    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          compared;
    int          mismatched;

    imem_loader #(
        .ADDR_W         (ADDR_W),
        .DEPTH_WORDS    (128),
        .MAGIC          (8'hA5),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .boot_req  (boot_req),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one byte for one cycle and score any write it produces
    task automatic send_byte(input logic [7:0] b);
        wr_t e;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (wr_en) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write",
                         wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== {e.addr, e.data}) begin
                    mismatched++;
                    $display("FAIL write: got addr %h data %h, required addr %h data %h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic pulse_boot();
        boot_req = 1'b1;
        @(posedge clk);
        #1;
        boot_req = 1'b0;
    endtask

    // Send a full frame from img[0..n-1]; csum_adj corrupts the checksum
    task automatic send_frame(input int n, input logic [7:0] csum_adj);
        logic [7:0]  sum;
        logic [15:0] nn;
        sum = 8'd0;
        nn  = 16'(n);
        send_byte(8'hA5);
        send_byte(nn[7:0]);
        send_byte(nn[15:8]);
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = img[i];
            exp_q.push_back('{addr: ADDR_W'(i * 4), data: w});
            for (int j = 0; j < 4; j++) begin
                logic [7:0] b;
                b   = w[j*8 +: 8];
                sum = sum + b;
                send_byte(b);
            end
        end
        send_byte(sum + csum_adj);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        compared++;
        if ({wr_en, wr_addr, wr_data, busy, core_hold, done, error, err_code} !== '0) begin
            mismatched++;
            $display("FAIL reset_values: got wr %b %h %h st %b%b%b%b%h, required all 0",
                     wr_en, wr_addr, wr_data, busy, core_hold, done, error, err_code);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        compared++;
        if ({busy, core_hold} !== 2'b00) begin
            mismatched++;
            $display("FAIL idle_after_reset: got busy %b hold %b, required 0 0", busy, core_hold);
        end
    endtask

    task automatic test_good_image();
        img = '{32'h00000513, 32'h00100593};
        pulse_boot();
        compared++;
        if ({busy, core_hold, done, error, err_code} !== 6'b110000) begin
            mismatched++;
            $display("FAIL boot_status: got %b, required 110000",
                     {busy, core_hold, done, error, err_code});
        end
        send_frame(2, 8'd0);
        compared++;
        if ({busy, core_hold, done, error, err_code} !== 6'b001000) begin
            mismatched++;
            $display("FAIL good_done: got %b, required 001000",
                     {busy, core_hold, done, error, err_code});
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL good_writes: got %0d missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bad_csum();
        img = '{32'h00000513, 32'h00100593};
        pulse_boot();
        send_frame(2, 8'd1);
        compared++;
        if ({busy, core_hold, done, error, err_code} !== 6'b010110) begin
            mismatched++;
            $display("FAIL csum_err: got %b, required 010110",
                     {busy, core_hold, done, error, err_code});
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL csum_writes: got %0d missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bad_len(input logic [7:0] lo, input logic [7:0] hi);
        pulse_boot();
        send_byte(8'hA5);
        send_byte(lo);
        send_byte(hi);
        send_byte(8'h13);
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h00);
        compared++;
        if ({busy, core_hold, done, error, err_code} !== 6'b010101) begin
            mismatched++;
            $display("FAIL bad_len %h%h: got %b, required 010101",
                     hi, lo, {busy, core_hold, done, error, err_code});
        end
    endtask

    task automatic test_hdr_garbage();
        img = '{32'hDEADBEEF, 32'h12345678, 32'h0000FFFF};
        pulse_boot();
        send_byte(8'h00);
        send_byte(8'hFF);
        compared++;
        if ({busy, core_hold, done, error} !== 4'b1100) begin
            mismatched++;
            $display("FAIL hdr_garbage: got %b, required 1100", {busy, core_hold, done, error});
        end
        send_frame(3, 8'd0);
        compared++;
        if ({busy, core_hold, done, error, err_code} !== 6'b001000 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL garbage_load: got %b pending %0d, required 001000 pending 0",
                     {busy, core_hold, done, error, err_code}, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_restart();
        img = '{32'hCAFEF00D, 32'h0BADC0DE};
        pulse_boot();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        pulse_boot();
        send_frame(2, 8'd0);
        compared++;
        if ({busy, core_hold, done, error, err_code} !== 6'b001000 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL restart: got %b pending %0d, required 001000 pending 0",
                     {busy, core_hold, done, error, err_code}, exp_q.size());
            exp_q.delete();
        end
    endtask

    // boot_req wins over a same-cycle byte; the MAGIC is dropped
    task automatic test_boot_collision();
        img = '{32'h01020304};
        boot_req = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        @(posedge clk);
        #1;
        boot_req = 1'b0;
        rx_valid = 1'b0;
        send_byte(8'h01);
        send_byte(8'h00);
        compared++;
        if ({busy, core_hold, done, error} !== 4'b1100) begin
            mismatched++;
            $display("FAIL collision: got %b, required 1100", {busy, core_hold, done, error});
        end
        send_frame(1, 8'd0);
        compared++;
        if ({done, error} !== 2'b10 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL collision_load: got done %b err %b pending %0d, required 1 0 0",
                     done, error, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Largest legal image, bytes on consecutive cycles, then one word too many
    task automatic test_back_to_back();
        img.delete();
        for (int i = 0; i < 128; i++) begin
            img.push_back($urandom);
        end
        pulse_boot();
        send_frame(128, 8'd0);
        compared++;
        if ({busy, core_hold, done, error, err_code} !== 6'b001000 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL max_image: got %b pending %0d, required 001000 pending 0",
                     {busy, core_hold, done, error, err_code}, exp_q.size());
            exp_q.delete();
        end
        test_bad_len(8'h81, 8'h00);
    endtask

    task automatic test_async_reset();
        pulse_boot();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        exp_q.push_back('{addr: ADDR_W'(0), data: 32'h00000513});
        send_byte(8'h13);
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h93);
        #2;
        reset = 1'b1;
        #1;
        compared++;
        if ({wr_en, wr_addr, wr_data, busy, core_hold, done, error, err_code} !== '0) begin
            mismatched++;
            $display("FAIL async_reset: got wr %b %h %h st %b%b%b%b%h, required all 0",
                     wr_en, wr_addr, wr_data, busy, core_hold, done, error, err_code);
        end
        @(negedge clk);
        reset = 1'b0;
        send_byte(8'hA5);
        compared++;
        if ({busy, core_hold} !== 2'b00 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL post_reset_idle: got busy %b hold %b pending %0d, required 0 0 0",
                     busy, core_hold, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_timeout();
        logic saw_wr;
        saw_wr = 1'b0;
        pulse_boot();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        repeat (150) begin
            @(posedge clk);
            #1;
            if (wr_en) saw_wr = 1'b1;
        end
        compared++;
        if (saw_wr !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_write: got wr_en during idle, required none");
        end
`ifdef IMEM_LOADER_TIMEOUT_EN
        compared++;
        if ({busy, core_hold, done, error, err_code} !== 6'b010111) begin
            mismatched++;
            $display("FAIL timeout: got %b, required 010111",
                     {busy, core_hold, done, error, err_code});
        end
`else
        compared++;
        if ({busy, core_hold, done, error, err_code} !== 6'b110000) begin
            mismatched++;
            $display("FAIL no_timeout: got %b, required 110000",
                     {busy, core_hold, done, error, err_code});
        end
`endif
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        boot_req   = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'd0;
        test_reset();
        test_good_image();
        test_bad_csum();
        test_bad_len(8'h00, 8'h00);
        test_bad_len(8'h81, 8'h00);
        test_hdr_garbage();
        test_restart();
        test_boot_collision();
        test_back_to_back();
        test_async_reset();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
